// File: rtl/genius_ctrl_if.sv
// Control/status bundle between the Genius sequencer and its datapath.
//   master : the sequencer -- drives R1, R2, E1..E4, SEL, state_o, won_o;
//            samples enter and the datapath status flags.
//   slave  : the datapath / top level -- the mirror image of master.
interface genius_ctrl_if;

  // User start/confirm request (synchronised, debounced)
  logic       enter;

  // Datapath status flags
  logic       end_FPGA;
  logic       end_User;
  logic       end_time;
  logic       win;
  logic       match;

  // Datapath control lines
  logic       R1;
  logic       R2;
  logic       E1;
  logic       E2;
  logic       E3;
  logic       E4;
  logic       SEL;

  // Debug / status
  logic [2:0] state_o;
  logic       won_o;

  modport master (
    input  enter, end_FPGA, end_User, end_time, win, match,
    output R1, R2, E1, E2, E3, E4, SEL, state_o, won_o
  );

  modport slave (
    output enter, end_FPGA, end_User, end_time, win, match,
    input  R1, R2, E1, E2, E3, E4, SEL, state_o, won_o
  );

endinterface

// File: rtl/genius_ctrl.sv
// Moore sequencer for the Genius game datapath.
// Steps through INIT -> SETUP -> (SEQ -> PLAY -> CHECK -> NEXT)* -> RESULT
// and drives the datapath clear/enable lines from the state it is entering,
// so every control line is valid in the first cycle of its state.
//
// Ports:
//   CLOCK_50 : system clock, rising edge
//   R        : synchronous active-high reset
//   bus      : genius_ctrl_if.master
//              in : enter, end_FPGA, end_User, end_time, win, match
//              out: R1, R2, E1..E4, SEL, state_o, won_o
module genius_ctrl #(
  parameter int unsigned RESULT_HOLD = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic          CLOCK_50,
  input  logic          R,
  genius_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    INIT   = 3'b000,
    SETUP  = 3'b001,
    SEQ    = 3'b010,
    PLAY   = 3'b011,
    CHECK  = 3'b100,
    NEXT   = 3'b101,
    RESULT = 3'b110
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(RESULT_HOLD);

  state_t           state;
  state_t           state_nxt;
  logic             enter_q;
  logic             start_p;
  logic             hold_done;
  logic             won;
  logic             won_nxt;
  logic [CNT_W-1:0] hold_cnt;

  logic             r1;
  logic             r2;
  logic             e1;
  logic             e2;
  logic             e3;
  logic             e4;
  logic             sel;

  // Transition function of the game sequencer.
  function automatic state_t next_state(
    input state_t s,
    input logic   start,
    input logic   hold_ok,
    input logic   fpga_done,
    input logic   user_done,
    input logic   timeout,
    input logic   seq_match,
    input logic   last_round
  );
    state_t n;
    n = s;
    case (s)
      INIT:    n = SETUP;
      SETUP:   if (start) n = SEQ;
      SEQ:     if (fpga_done) n = PLAY;
      // A completed entry beats a timeout that lands in the same cycle.
      PLAY: begin
        if (user_done)    n = CHECK;
        else if (timeout) n = RESULT;
      end
      CHECK: begin
        if (seq_match && !last_round) n = NEXT;
        else                          n = RESULT;
      end
      NEXT:    n = SEQ;
      // Early starts are dropped so the result stays on screen long enough.
      RESULT:  if (start && hold_ok) n = INIT;
      default: n = INIT;
    endcase
    return n;
  endfunction

  // Win flag is captured when RESULT is entered from CHECK and held there.
  function automatic logic next_won(
    input state_t s,
    input state_t n,
    input logic   seq_match,
    input logic   last_round,
    input logic   won_cur
  );
    logic w;
    w = 1'b0;
    if (n == RESULT) begin
      if (s == RESULT)     w = won_cur;
      else if (s == CHECK) w = seq_match & last_round;
    end
    return w;
  endfunction

  // A held key produces one start pulse only.
  assign start_p   = bus.enter & ~enter_q;
  assign hold_done = (hold_cnt == HOLD_MAX);

  assign state_nxt = next_state(state, start_p, hold_done, bus.end_FPGA,
                                bus.end_User, bus.end_time, bus.match, bus.win);
  assign won_nxt   = next_won(state, state_nxt, bus.match, bus.win, won);

  // State, hold counter and registered Moore outputs decoded from next state.
  always_ff @(posedge CLOCK_50) begin
    if (R) begin
      state    <= INIT;
      enter_q  <= 1'b0;
      hold_cnt <= '0;
      won      <= 1'b0;
      r1       <= 1'b1;
      r2       <= 1'b1;
      e1       <= 1'b0;
      e2       <= 1'b0;
      e3       <= 1'b0;
      e4       <= 1'b0;
      sel      <= 1'b0;
    end else begin
      state   <= state_nxt;
      enter_q <= bus.enter;
      won     <= won_nxt;

      // Restart the hold on every entry to RESULT, saturate while there.
      if (state_nxt == RESULT && state != RESULT) begin
        hold_cnt <= '0;
      end else if (state == RESULT && !hold_done) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end

      r1  <= (state_nxt == INIT);
      r2  <= (state_nxt == INIT) || (state_nxt == NEXT);
      e1  <= (state_nxt == SETUP);
      e2  <= (state_nxt == PLAY);
      e3  <= (state_nxt == SEQ);
      e4  <= (state_nxt == NEXT);
      sel <= (state_nxt == RESULT);
    end
  end

  assign bus.R1      = r1;
  assign bus.R2      = r2;
  assign bus.E1      = e1;
  assign bus.E2      = e2;
  assign bus.E3      = e3;
  assign bus.E4      = e4;
  assign bus.SEL     = sel;
  assign bus.state_o = state;
  assign bus.won_o   = won;

endmodule

// File: tb/tb_genius_ctrl.sv
// Scoreboard bench for genius_ctrl: the stimulus thread pushes the expected
// state/won pair for each clock it drives; a monitor pops one entry per clock
// and compares state_o and all control outputs.
module tb_genius_ctrl;

  localparam logic [2:0] S_INIT   = 3'b000;
  localparam logic [2:0] S_SETUP  = 3'b001;
  localparam logic [2:0] S_SEQ    = 3'b010;
  localparam logic [2:0] S_PLAY   = 3'b011;
  localparam logic [2:0] S_CHECK  = 3'b100;
  localparam logic [2:0] S_NEXT   = 3'b101;
  localparam logic [2:0] S_RESULT = 3'b110;

  typedef struct {
    logic [2:0] st;
    logic       won;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  genius_ctrl_if bus();

  genius_ctrl #(.RESULT_HOLD(20), .CNT_W(5)) dut (
    .CLOCK_50(clk),
    .R       (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {R1,R2,E1,E2,E3,E4,SEL,won_o} for each state.
  function automatic logic [7:0] exp_outs(input logic [2:0] st, input logic wn);
    case (st)
      S_INIT:   return 8'b1100_0000;
      S_SETUP:  return 8'b0010_0000;
      S_SEQ:    return 8'b0000_1000;
      S_PLAY:   return 8'b0001_0000;
      S_CHECK:  return 8'b0000_0000;
      S_NEXT:   return 8'b0100_0100;
      S_RESULT: return {7'b0000_001, wn};
      default:  return 8'b0000_0000;
    endcase
  endfunction

  // Drive one clock of inputs and queue what must be seen after that edge.
  task automatic step(input logic r, input logic en, input logic ef,
                      input logic eu, input logic et, input logic m,
                      input logic w, input logic [2:0] st, input logic wn,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.enter    = en;
    bus.end_FPGA = ef;
    bus.end_User = eu;
    bus.end_time = et;
    bus.match    = m;
    bus.win      = w;
    e.st   = st;
    e.won  = wn;
    e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: one comparison per clock, sampled 1 time unit after the edge.
  initial begin
    exp_t       e;
    logic [7:0] act;
    logic [7:0] req;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {bus.R1, bus.R2, bus.E1, bus.E2, bus.E3, bus.E4, bus.SEL, bus.won_o};
        req = exp_outs(e.st, e.won);
        checks++;
        if (bus.state_o !== e.st || act !== req) begin
          errors++;
          $display("FAIL %s: got state %b outs %b, expected state %b outs %b",
                   e.name, bus.state_o, act, e.st, req);
        end
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.enter    = 1'b0;
    bus.end_FPGA = 1'b0;
    bus.end_User = 1'b0;
    bus.end_time = 1'b0;
    bus.match    = 1'b0;
    bus.win      = 1'b0;

    // Reset, then release into SETUP
    step(1,0,0,0,0,0,0, S_INIT,   0, "reset_1");
    step(1,0,0,0,0,0,0, S_INIT,   0, "reset_2");
    step(0,0,0,0,0,0,0, S_SETUP,  0, "release");
    step(0,0,0,0,0,0,0, S_SETUP,  0, "setup_idle");

    // Winning first round
    step(0,1,0,0,0,0,0, S_SEQ,    0, "start_to_seq");
    step(0,1,0,0,0,0,0, S_SEQ,    0, "seq_held_key");
    step(0,0,1,0,0,0,0, S_PLAY,   0, "fpga_done");
    step(0,0,0,0,0,0,0, S_PLAY,   0, "play_idle");
    step(0,0,0,1,0,1,0, S_CHECK,  0, "user_done");
    step(0,0,0,0,0,1,0, S_NEXT,   0, "match_next");
    step(0,0,0,0,0,0,0, S_SEQ,    0, "next_to_seq");

    // Final round: simultaneous end_time/end_User goes to CHECK, then win
    step(0,0,1,0,0,0,0, S_PLAY,   0, "fpga_done_r2");
    step(0,0,0,1,1,1,0, S_CHECK,  0, "user_beats_timeout");
    step(0,0,0,0,0,1,1, S_RESULT, 1, "final_win");

    // Held key inside the hold window: single edge, discarded
    for (int i = 0; i < 10; i++) step(0,1,0,0,0,0,0, S_RESULT, 1, "win_hold_key");
    for (int i = 0; i < 15; i++) step(0,0,0,0,0,0,0, S_RESULT, 1, "win_wait");
    step(0,1,0,0,0,0,0, S_INIT,   0, "restart_after_win");
    step(0,0,0,0,0,0,0, S_SETUP,  0, "setup_after_win");

    // Timeout loss
    step(0,1,0,0,0,0,0, S_SEQ,    0, "start_g2");
    step(0,0,0,0,1,0,0, S_SEQ,    0, "seq_ignores_time");
    step(0,0,1,0,0,0,0, S_PLAY,   0, "fpga_done_g2");
    step(0,0,0,0,1,0,0, S_RESULT, 0, "timeout_loss");
    for (int i = 0; i < 25; i++) step(0,0,0,0,0,0,0, S_RESULT, 0, "loss_wait");
    step(0,1,0,0,0,0,0, S_INIT,   0, "restart_after_loss");
    step(0,0,0,0,0,0,0, S_SETUP,  0, "setup_g3");

    // Mismatch, then hold boundary: pulse at count 19 dropped, at 20 taken
    step(0,1,0,0,0,0,0, S_SEQ,    0, "start_g3");
    step(0,0,1,0,0,0,0, S_PLAY,   0, "fpga_done_g3");
    step(0,0,0,1,0,0,0, S_CHECK,  0, "user_done_g3");
    step(0,0,0,0,0,0,0, S_RESULT, 0, "mismatch_loss");
    for (int i = 0; i < 19; i++) step(0,0,0,0,0,0,0, S_RESULT, 0, "mismatch_wait");
    step(0,1,0,0,0,0,0, S_RESULT, 0, "start_at_hold_minus_1");
    step(0,0,0,0,0,0,0, S_RESULT, 0, "key_release");
    step(0,1,0,0,0,0,0, S_INIT,   0, "start_at_hold");
    step(0,0,0,0,0,0,0, S_SETUP,  0, "setup_g4");

    // Mid-game reset from SEQ
    step(0,1,0,0,0,0,0, S_SEQ,    0, "start_g4");
    step(0,0,0,1,1,0,0, S_SEQ,    0, "seq_ignores_user");
    step(1,0,0,0,0,0,0, S_INIT,   0, "midgame_reset");
    step(0,0,0,0,0,0,0, S_SETUP,  0, "post_reset_setup");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
